// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ valid/ready requesters into one registered
// output stage; an owner keeps the grant for up to MAX_BURST consecutive beats.
module fifo_rr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [ID_WIDTH-1:0]           out_id_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  // Handshake rule on both sides: a beat moves on a cycle where valid and ready are
  // both high at the rising clock edge; a raised valid stays up until it is accepted.

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   sel;
  logic [ID_WIDTH-1:0]   xfer_id;
  logic                  any_valid;
  logic                  pipe_free;
  logic                  xfer;
  logic [NUM_REQ-1:0]    ready;

  assign pipe_free = !out_valid_o || out_ready_i;

  // Scan starts one past the last grant so the previous winner is looked at last.
  always_comb begin
    sel       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_valid && req_valid_i[(int'(last_q) + 1 + i) % NUM_REQ]) begin
        sel       = ID_WIDTH'((int'(last_q) + 1 + i) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ready   = '0;
    case (state_q)
      IDLE: begin
        if (pipe_free && any_valid) begin
          ready[sel] = 1'b1;
          owner_d    = sel;
          last_d     = sel;
          cnt_d      = CNT_WIDTH'(1);
          state_d    = (MAX_BURST > 1) ? BURST : IDLE;
        end
      end
      BURST: begin
        ready[owner_q] = pipe_free;
        if (pipe_free) begin
          if (req_valid_i[owner_q]) begin
            cnt_d = CNT_WIDTH'(int'(cnt_q) + 1);
            if (int'(cnt_q) + 1 == MAX_BURST) state_d = IDLE;
          end else begin
            // Owner went quiet with room downstream: give up the rest of the burst.
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is masked by reset so nothing is accepted while the block is held in reset.
  assign req_ready_o = arst_ni ? ready : '0;
  assign xfer        = |(req_valid_i & req_ready_o);
  assign xfer_id     = (state_q == IDLE) ? sel : owner_q;
  assign busy_o      = (state_q == BURST);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
    end else if (xfer) begin
      out_valid_o <= 1'b1;
      out_data_o  <= req_data_i[int'(xfer_id)*DATA_WIDTH +: DATA_WIDTH];
      out_id_o    <= xfer_id;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
